// File: rtl/x87_seq_ctrl.sv
// x87_seq_ctrl: x87 register-stack sequencer driving the FP register file, FP ALU and FP memory port.
module x87_seq_ctrl #(
  parameter logic [2:0] TOP_RESET   = 3'd0,
  parameter int         ALU_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [4:0] cmd,
  input  logic [2:0] cmd_idx,
  output logic       cmd_ready,
  output logic [2:0] rf_rd_a,
  output logic [2:0] rf_rd_b,
  output logic       rf_we,
  output logic [2:0] rf_wr_addr,
  output logic [1:0] rf_wr_sel,
  output logic       rf_swap,
  output logic       alu_start,
  output logic [2:0] alu_op,
  input  logic       alu_done,
  input  logic [2:0] alu_cc,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_dbl,
  input  logic       mem_ack,
  output logic [2:0] top,
  output logic [7:0] tag_valid,
  output logic [3:0] cc,
  output logic       stack_fault,
  output logic       seq_error
);
  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_ALU = 2'd2, S_MEM = 2'd3;
  logic [1:0] state;
  logic [4:0] c_cmd;
  logic [2:0] c_idx;
  logic [CW-1:0] cnt;
  logic [2:0] p0, pi, pm;
  logic is_ninit, is_ldm, is_stm, is_ldst, is_xch, is_ststi, is_alu, is_cmp, is_popalu, is_mem;
  logic needs0, needsi, under, over, fault, exec_ok;
  logic mem_act, mem_done, alu_fin, timeout, do_push, do_pop, c1_clr;

  assign p0 = top;
  assign pi = top + c_idx;
  assign pm = top - 3'd1;

  assign is_ninit  = c_cmd == 5'd2;
  assign is_ldm    = c_cmd == 5'd6 || c_cmd == 5'd7;
  assign is_stm    = c_cmd == 5'd8 || c_cmd == 5'd9;
  assign is_ldst   = c_cmd == 5'd10;
  assign is_xch    = c_cmd == 5'd11;
  assign is_ststi  = c_cmd == 5'd12;
  assign is_alu    = c_cmd >= 5'd20 && c_cmd <= 5'd29;
  assign is_cmp    = c_cmd == 5'd23 || c_cmd == 5'd26;
  assign is_popalu = c_cmd >= 5'd27 && c_cmd <= 5'd29;
  assign is_mem    = is_ldm | is_stm;

  // Underflow is checked before overflow, so a push reading an empty source reports C1=0.
  assign needs0  = is_stm | is_ststi | is_xch | is_alu;
  assign needsi  = is_ldst | is_xch | is_alu;
  assign under   = (needs0 & ~tag_valid[p0]) | (needsi & ~tag_valid[pi]);
  assign over    = (is_ldm | is_ldst) & tag_valid[pm];
  assign fault   = under | over;
  assign exec_ok = state == S_EXEC && !fault;

  assign mem_act  = (exec_ok & is_mem) | (state == S_MEM);
  assign mem_done = mem_act & mem_ack;
  assign alu_fin  = state == S_ALU && alu_done;
  assign timeout  = state == S_ALU && !alu_done && cnt == CW'(ALU_TIMEOUT - 1);
  assign do_push  = (exec_ok & is_ldst) | (mem_done & is_ldm);
  assign do_pop   = (exec_ok & is_ststi) | (alu_fin & (is_popalu | c_cmd == 5'd26)) | (mem_done & is_stm);
  assign c1_clr   = (exec_ok & (is_ldst | is_xch | is_ststi)) | (alu_fin & ~is_cmp) | mem_done;

  assign cmd_ready  = state == S_IDLE;
  assign rf_rd_a    = (is_ldst | is_popalu) ? pi : p0;
  assign rf_rd_b    = is_popalu ? p0 : pi;
  assign rf_swap    = exec_ok & is_xch;
  assign alu_start  = exec_ok & is_alu;
  assign mem_req    = mem_act;
  assign mem_we     = mem_act & is_stm;
  assign mem_dbl    = c_cmd[0];
  assign rf_we      = (exec_ok & (is_ldst | is_ststi)) | (alu_fin & ~is_cmp) | (mem_done & is_ldm);
  assign rf_wr_addr = (is_ldst | is_ldm) ? pm : (is_ststi | is_popalu) ? pi : p0;
  assign rf_wr_sel  = is_ldm ? 2'd2 : (is_ldst | is_ststi) ? 2'd1 : 2'd0;

  always_comb begin
    alu_op = 3'd0;
    case (c_cmd)
      5'd21, 5'd28: alu_op = 3'd3;
      5'd22, 5'd29: alu_op = 3'd4;
      5'd23, 5'd26: alu_op = 3'd5;
      5'd24:        alu_op = 3'd1;
      5'd25:        alu_op = 3'd2;
      default:      alu_op = 3'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      c_cmd       <= '0;
      c_idx       <= '0;
      cnt         <= '0;
      top         <= TOP_RESET;
      tag_valid   <= '0;
      cc          <= '0;
      stack_fault <= 1'b0;
      seq_error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          state <= S_EXEC;
          c_cmd <= cmd;
          c_idx <= cmd_idx;
        end
        S_EXEC: begin
          cnt   <= '0;
          state <= (exec_ok & is_alu) ? S_ALU : (exec_ok & is_mem & ~mem_ack) ? S_MEM : S_IDLE;
        end
        S_ALU: if (alu_done | timeout) state <= S_IDLE;
               else cnt <= cnt + CW'(1);
        default: if (mem_ack) state <= S_IDLE;
      endcase
      if (state == S_EXEC && fault) begin
        stack_fault <= 1'b1;
        cc[1]       <= ~under;
      end
      if (c1_clr) cc[1] <= 1'b0;
      if (alu_fin & is_cmp) cc <= {alu_cc[2], alu_cc[1], 1'b0, alu_cc[0]};
      if (timeout) seq_error <= 1'b1;
      // The pop clear is ordered last so FSTP ST(0) ends with the entry empty.
      if (exec_ok & is_ststi) tag_valid[pi] <= 1'b1;
      if (do_push) begin
        top           <= pm;
        tag_valid[pm] <= 1'b1;
      end
      if (do_pop) begin
        top           <= p0 + 3'd1;
        tag_valid[p0] <= 1'b0;
      end
      if (exec_ok & is_ninit) begin
        top         <= TOP_RESET;
        tag_valid   <= '0;
        cc          <= '0;
        stack_fault <= 1'b0;
        seq_error   <= 1'b0;
      end
    end
  end
endmodule
